// File: rtl/clk_divider_prog.sv
// Multi-channel programmable clock-enable generator. Each channel divides clk_in by N and emits a
// one-cycle tick plus a ~50% square wave. New divisors apply only at a period boundary or on sync.
module clk_divider_prog #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 2,
    parameter int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic              div_wr,
    input  logic [SEL_W-1:0]  div_sel,
    input  logic [CNT_W-1:0]  div_val,
    output logic              div_ack,
    output logic              div_err,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_out
);

    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [SEL_W:0]   NUM_CH_S = (SEL_W + 1)'(NUM_CH);

    logic [CNT_W-1:0]  cnt_q      [NUM_CH];
    logic [CNT_W-1:0]  cnt_d      [NUM_CH];
    logic [CNT_W-1:0]  div_cur_q  [NUM_CH];
    logic [CNT_W-1:0]  div_cur_d  [NUM_CH];
    logic [CNT_W-1:0]  div_pend_q [NUM_CH];
    logic [CNT_W-1:0]  div_pend_d [NUM_CH];
    logic [NUM_CH-1:0] pend_v_q, pend_v_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic              wr_ok;

    always_comb begin
        wr_ok = ({1'b0, div_sel} < NUM_CH_S) && (div_val >= CNT_W'(2));
        ack_d = div_wr & wr_ok;
        err_d = div_wr & ~wr_ok;
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]      = cnt_q[i];
            div_cur_d[i]  = div_cur_q[i];
            div_pend_d[i] = div_pend_q[i];
            pend_v_d[i]   = pend_v_q[i];
            tick_d[i]     = 1'b0;
            clk_out_d[i]  = clk_out_q[i];
            // A boundary (wrap or sync) consumes the pending divisor held before this cycle's write.
            if (sync || (en[i] && (cnt_q[i] == div_cur_q[i] - CNT_W'(1)))) begin
                cnt_d[i]    = '0;
                pend_v_d[i] = 1'b0;
                tick_d[i]   = ~sync;
                if (pend_v_q[i]) begin
                    div_cur_d[i] = div_pend_q[i];
                end
            end else if (en[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (sync || en[i]) begin
                clk_out_d[i] = (cnt_d[i] < (div_cur_d[i] >> 1));
            end
            if (ack_d && (div_sel == SEL_W'(i))) begin
                div_pend_d[i] = div_val;
                pend_v_d[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= '0;
                div_cur_q[i]  <= DEF_DIV;
                div_pend_q[i] <= DEF_DIV;
            end
            pend_v_q  <= '0;
            tick_q    <= '0;
            clk_out_q <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i]      <= cnt_d[i];
                div_cur_q[i]  <= div_cur_d[i];
                div_pend_q[i] <= div_pend_d[i];
            end
            pend_v_q  <= pend_v_d;
            tick_q    <= tick_d;
            clk_out_q <= clk_out_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    assign div_ack = ack_q;
    assign div_err = err_q;
    assign pend    = pend_v_q;
    assign tick    = tick_q;
    assign clk_out = clk_out_q;

endmodule
